// File: rtl/hangman_round_ctrl.sv
// Hangman round controller: lives/revealed tracking, per-guess timeout and timer handshake,
// plus registered BCD time digits. Optional low-time warning under LOW_TIME_WARN_EN.
module hangman_round_ctrl #(
  parameter int unsigned MAX_LIVES = 6,
  parameter int unsigned WORD_LEN  = 4
`ifdef LOW_TIME_WARN_EN
  ,
  parameter int unsigned WARN_THRESH = 3
`endif
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic       guess_valid,
  input  logic       guess_hit,
  input  logic [5:0] counter_val,
  output logic       timer_load,
  output logic       timer_enable,
  output logic [2:0] lives,
  output logic [2:0] revealed,
  output logic [2:0] state,
  output logic       game_won,
  output logic       game_lost,
  output logic [3:0] time_tens,
  output logic [3:0] time_ones,
  output logic       warn
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_PLAY = 3'd2,
    S_WON  = 3'd3,
    S_LOST = 3'd4
  } state_t;

  state_t     state_q;
  logic [5:0] prev_cv;
  logic       load_d1;
  logic       timeout;

  assign state = state_q;

  // A 1->0 edge on the countdown is only trusted once the timer has had a cycle to reload.
  assign timeout = (state_q == S_PLAY) && (counter_val == 6'd0) && (prev_cv != 6'd0)
                   && !timer_load && !load_d1;

  // NOTE: all state here updates with non-blocking assignments so every register
  // samples the pre-edge values; blocking would make the outcome order-dependent.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      lives        <= 3'd0;
      revealed     <= 3'd0;
      timer_load   <= 1'b0;
      timer_enable <= 1'b0;
      game_won     <= 1'b0;
      game_lost    <= 1'b0;
      prev_cv      <= 6'd0;
      load_d1      <= 1'b0;
    end else begin
      prev_cv    <= counter_val;
      load_d1    <= timer_load;
      timer_load <= 1'b0;
      case (state_q)
        S_IDLE, S_WON, S_LOST: begin
          if (start) begin
            state_q    <= S_ARM;
            timer_load <= 1'b1;
            game_won   <= 1'b0;
            game_lost  <= 1'b0;
          end
        end
        S_ARM: begin
          lives        <= 3'(MAX_LIVES);
          revealed     <= 3'd0;
          state_q      <= S_PLAY;
          timer_enable <= 1'b1;
        end
        S_PLAY: begin
          if (guess_valid && guess_hit) begin
            revealed   <= revealed + 3'd1;
            timer_load <= 1'b1;
            if (revealed == 3'(WORD_LEN - 1)) begin
              state_q      <= S_WON;
              timer_enable <= 1'b0;
              game_won     <= 1'b1;
            end
          end else if (guess_valid || timeout) begin
            timer_load <= 1'b1;
            if (lives <= 3'd1) begin
              lives        <= 3'd0;
              state_q      <= S_LOST;
              timer_enable <= 1'b0;
              game_lost    <= 1'b1;
            end else begin
              lives <= lives - 3'd1;
            end
          end
        end
        default: begin
          state_q      <= S_IDLE;
          timer_enable <= 1'b0;
        end
      endcase
    end
  end

  // Display digits follow the timer regardless of round state.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      time_tens <= 4'd0;
      time_ones <= 4'd0;
    end else begin
      time_tens <= 4'(counter_val / 6'd10);
      time_ones <= 4'(counter_val % 6'd10);
    end
  end

`ifdef LOW_TIME_WARN_EN
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) warn <= 1'b0;
    else       warn <= (state_q == S_PLAY) && (counter_val <= 6'(WARN_THRESH));
  end
`else
  assign warn = 1'b0;
`endif

endmodule
